// File: rtl/uart_pkg.sv
// Shared UART constants and the baud divisor helper.
// The optional fractional divisor is enabled by defining BAUD_FRAC_EN.
package uart_pkg;

  localparam int unsigned UART_OVS_DEFAULT = 16;
  localparam int unsigned UART_DIV_W       = 11;
  localparam int unsigned UART_FRAC_W      = 4;
  // 100 MHz clock, 9600 baud, 16x oversampling
  localparam int unsigned UART_DIV_RST     = 650;

  // Integer divisor for a given clock and baud rate: round-to-nearest, minus one,
  // because the sample period is div_int+1 clock cycles.
  function automatic int unsigned baud_div(input longint unsigned clk_hz,
                                           input longint unsigned baud,
                                           input longint unsigned ovs);
    longint unsigned den;
    longint unsigned quo;
    den = baud * ovs;
    quo = (clk_hz + den / 2) / den;
    return int'(unsigned'(quo[31:0])) - 1;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Fixed-modulus up-counter with synchronous clear and a wrap flag.
// wrap is high while the count sits at MOD-1; the next enabled edge returns it to zero.
module mod_counter #(
  parameter int unsigned W   = 4,
  parameter int unsigned MOD = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] value,
  output logic         wrap
);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;

  assign wrap  = (value_q == W'(MOD - 1));
  assign value = value_q;

  // Next count: clear wins, otherwise advance and wrap at MOD-1.
  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (en) begin
      value_d = wrap ? '0 : value_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

endmodule

// File: rtl/baud_tick_gen.sv
// Programmable UART baud tick generator.
// A runtime divisor sets the oversampling period; a mod-OVS counter turns sample ticks into
// bit-centre (mid_tick) and bit-end (bit_tick) strobes. Divisor updates go through a shadow
// register and take effect only at a period boundary or on restart.
// Define BAUD_FRAC_EN to add a fractional divisor via a phase accumulator.
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int unsigned DIV_W   = UART_DIV_W,
  parameter int unsigned FRAC_W  = UART_FRAC_W,
  parameter int unsigned OVS     = UART_OVS_DEFAULT,
  parameter int unsigned DIV_RST = UART_DIV_RST
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              restart,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  output logic              sample_tick,
  output logic              mid_tick,
  output logic              bit_tick
);

  localparam int unsigned OVS_W = $clog2(OVS);

`ifdef BAUD_FRAC_EN
  // One extra bit so a lengthened period at the largest divisor is still reachable.
  localparam int unsigned CNT_W = DIV_W + 1;
`else
  localparam int unsigned CNT_W = DIV_W;
`endif

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] div_sh_q, div_sh_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] lim;
  logic             tick;
  logic [OVS_W-1:0] ovs_cnt;
  logic             ovs_wrap;

`ifdef BAUD_FRAC_EN
  logic [FRAC_W-1:0] frac_q, frac_d;
  logic [FRAC_W-1:0] frac_sh_q, frac_sh_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              long_q, long_d;
  logic [FRAC_W:0]   acc_sum;

  assign acc_sum = {1'b0, acc_q} + {1'b0, frac_q};
  assign lim     = {1'b0, div_q} + {{DIV_W{1'b0}}, long_q};
`else
  logic unused_div_frac;

  assign unused_div_frac = ^div_frac;
  assign lim             = div_q;
`endif

  // Strobes decode registered state; reset forces them low without waiting for a clock.
  assign tick        = en & ~restart & ~reset & (cnt_q == lim);
  assign sample_tick = tick;
  assign mid_tick    = tick & (ovs_cnt == OVS_W'(OVS / 2 - 1));
  assign bit_tick    = tick & ovs_wrap;

  mod_counter #(
    .W   (OVS_W),
    .MOD (OVS)
  ) u_ovs_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (tick),
    .clr   (restart),
    .value (ovs_cnt),
    .wrap  (ovs_wrap)
  );

  // Next state for the period counter, active/shadow divisor and fractional accumulator.
  always_comb begin
    cnt_d    = cnt_q;
    div_d    = div_q;
    div_sh_d = div_sh_q;
    pend_d   = pend_q;
`ifdef BAUD_FRAC_EN
    frac_d    = frac_q;
    frac_sh_d = frac_sh_q;
    acc_d     = acc_q;
    long_d    = long_q;
`endif
    if (restart) begin
      cnt_d = '0;
`ifdef BAUD_FRAC_EN
      acc_d  = '0;
      long_d = 1'b0;
`endif
      if (div_load) begin
        // A divisor loaded together with restart governs the very first period.
        div_d    = div_int;
        div_sh_d = div_int;
        pend_d   = 1'b0;
`ifdef BAUD_FRAC_EN
        frac_d    = div_frac;
        frac_sh_d = div_frac;
`endif
      end else if (pend_q) begin
        div_d  = div_sh_q;
        pend_d = 1'b0;
`ifdef BAUD_FRAC_EN
        frac_d = frac_sh_q;
`endif
      end
    end else begin
      if (tick) begin
        cnt_d = '0;
`ifdef BAUD_FRAC_EN
        // The carry uses the fraction of the period just ending.
        acc_d  = acc_sum[FRAC_W-1:0];
        long_d = acc_sum[FRAC_W];
`endif
        if (pend_q) begin
          div_d  = div_sh_q;
          pend_d = 1'b0;
`ifdef BAUD_FRAC_EN
          frac_d = frac_sh_q;
`endif
        end
      end else if (en) begin
        cnt_d = cnt_q + 1'b1;
      end
      // Shadow capture works even while disabled; a load on a wrap pends to the next wrap.
      if (div_load) begin
        div_sh_d = div_int;
        pend_d   = 1'b1;
`ifdef BAUD_FRAC_EN
        frac_sh_d = div_frac;
`endif
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      div_q    <= DIV_W'(DIV_RST);
      div_sh_q <= DIV_W'(DIV_RST);
      pend_q   <= 1'b0;
`ifdef BAUD_FRAC_EN
      frac_q    <= '0;
      frac_sh_q <= '0;
      acc_q     <= '0;
      long_q    <= 1'b0;
`endif
    end else begin
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      div_sh_q <= div_sh_d;
      pend_q   <= pend_d;
`ifdef BAUD_FRAC_EN
      frac_q    <= frac_d;
      frac_sh_q <= frac_sh_d;
      acc_q     <= acc_d;
      long_q    <= long_d;
`endif
    end
  end

endmodule

// File: tb/tb_baud_tick_gen.sv
// Self-checking bench for baud_tick_gen: directed scenarios plus randomized traffic, every
// cycle compared against a behavioural period/tick-count model.
module tb_baud_tick_gen;

  localparam int OVS     = 16;
  localparam int DIV_RST = 650;
  localparam int FRAC_M  = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        restart;
  logic [10:0] div_int;
  logic [3:0]  div_frac;
  logic        div_load;
  logic        sample_tick;
  logic        mid_tick;
  logic        bit_tick;

  baud_tick_gen u_dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .restart     (restart),
    .div_int     (div_int),
    .div_frac    (div_frac),
    .div_load    (div_load),
    .sample_tick (sample_tick),
    .mid_tick    (mid_tick),
    .bit_tick    (bit_tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: elapsed cycles in the current period, tick count since restart, divisors.
  int m_el, m_ticks, m_div, m_sh, m_frac, m_fsh, m_pend, m_acc, m_long;

  // Observations of DUT strobes.
  int cyc, last_s, last_m, last_b, s_int, m_int, b_int, tick_cnt;
  int rs_cyc, first_s, first_m;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_el = 0; m_ticks = 0; m_div = DIV_RST; m_sh = DIV_RST;
    m_frac = 0; m_fsh = 0; m_pend = 0; m_acc = 0; m_long = 0;
    last_s = -1; last_m = -1; last_b = -1; s_int = 0; m_int = 0; b_int = 0;
  endtask

  // One clock cycle: drive, compare against the model, then advance the model at the edge.
  task automatic step(input logic e, input logic r, input logic l, input int di, input int df);
    logic exp_s, exp_m, exp_b;
    en = e; restart = r; div_load = l;
    div_int = 11'(di); div_frac = 4'(df);
    #2;
    exp_s = e && !r && (m_el == m_div + m_long);
    exp_m = exp_s && ((m_ticks % OVS) == OVS / 2 - 1);
    exp_b = exp_s && ((m_ticks % OVS) == OVS - 1);
    check_eq("sample_tick", 32'(sample_tick), 32'(exp_s));
    check_eq("mid_tick", 32'(mid_tick), 32'(exp_m));
    check_eq("bit_tick", 32'(bit_tick), 32'(exp_b));
    if (sample_tick === 1'b1) begin
      if (last_s >= 0) s_int = cyc - last_s;
      last_s = cyc;
      tick_cnt++;
    end
    if (mid_tick === 1'b1) begin
      if (last_m >= 0) m_int = cyc - last_m;
      last_m = cyc;
    end
    if (bit_tick === 1'b1) begin
      if (last_b >= 0) b_int = cyc - last_b;
      last_b = cyc;
    end
    if (r) begin
      rs_cyc = cyc; first_s = -1; first_m = -1;
    end else begin
      if (sample_tick === 1'b1 && first_s < 0) first_s = cyc;
      if (mid_tick === 1'b1 && first_m < 0) first_m = cyc;
    end
    @(posedge clk);
    if (r) begin
      m_el = 0; m_ticks = 0; m_acc = 0; m_long = 0;
      if (l) begin
        m_div = di; m_sh = di; m_frac = df; m_fsh = df; m_pend = 0;
      end else if (m_pend != 0) begin
        m_div = m_sh; m_frac = m_fsh; m_pend = 0;
      end
    end else begin
      if (exp_s) begin
        m_el = 0;
        m_ticks++;
`ifdef BAUD_FRAC_EN
        m_acc  = m_acc + m_frac;
        m_long = (m_acc >= FRAC_M) ? 1 : 0;
        m_acc  = m_acc % FRAC_M;
`endif
        if (m_pend != 0) begin
          m_div = m_sh; m_frac = m_fsh; m_pend = 0;
        end
      end else if (e) begin
        m_el++;
      end
      if (l) begin
        m_sh = di; m_fsh = df; m_pend = 1;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic run(input int n, input int di);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, di, 0);
  endtask

  int t0, n0, exp_span;

  initial begin
    cyc = 0; tick_cnt = 0; rs_cyc = 0; first_s = -1; first_m = -1;
    model_reset();
    reset = 1'b1; en = 1'b1; restart = 1'b0; div_load = 1'b0;
    div_int = '0; div_frac = '0;
    #1;
    check_eq("rst_sample", 32'(sample_tick), 32'd0);
    check_eq("rst_bit", 32'(bit_tick), 32'd0);
    @(posedge clk); @(posedge clk);
    #1 reset = 1'b0;

    // Default divisor: 651-cycle sample period, 16 of them per bit.
    run(21000, 0);
    check_eq("dflt_sample_period", 32'(s_int), 32'd651);
    check_eq("dflt_mid_period", 32'(m_int), 32'd10416);
    check_eq("dflt_bit_period", 32'(b_int), 32'd10416);

    // Mid-period load of 3 finishes the old period first.
    run(100, 0);
    step(1'b1, 1'b0, 1'b1, 3, 0);
    run(900, 3);
    check_eq("div3_sample_period", 32'(s_int), 32'd4);
    check_eq("div3_mid_period", 32'(m_int), 32'd64);
    check_eq("div3_bit_period", 32'(b_int), 32'd64);

    // Restart at arbitrary phases re-aligns the first tick and bit centre.
    for (int k = 0; k < 3; k++) begin
      run(int'($urandom_range(0, 50)), 3);
      step(1'b1, 1'b1, 1'b0, 3, 0);
      run(40, 3);
      check_eq("restart_first_sample", 32'(first_s - rs_cyc), 32'd4);
      check_eq("restart_first_mid", 32'(first_m - rs_cyc), 32'd32);
    end

    // Divisor 0: tick every enabled cycle; disabled cycles freeze everything.
    step(1'b1, 1'b0, 1'b1, 0, 0);
    run(10, 0);
    check_eq("div0_sample_period", 32'(s_int), 32'd1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 0, 0);
    run(40, 0);
    check_eq("div0_after_hold", 32'(s_int), 32'd1);

    // Fractional divisor 4 + 8/16: 32 ticks take 176 cycles (160 without the fraction).
    step(1'b1, 1'b1, 1'b1, 4, 8);
    n0 = tick_cnt;
    for (int i = 0; i < 20 && tick_cnt == n0; i++) step(1'b1, 1'b0, 1'b0, 4, 8);
    t0 = last_s; n0 = tick_cnt;
    for (int i = 0; i < 400 && tick_cnt < n0 + 32; i++) step(1'b1, 1'b0, 1'b0, 4, 8);
`ifdef BAUD_FRAC_EN
    exp_span = 176;
`else
    exp_span = 160;
`endif
    check_eq("frac_32_tick_span", 32'(last_s - t0), 32'(exp_span));

    // Randomized enable/restart/load traffic with small divisors.
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 9) != 0), ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 19) == 0), int'($urandom_range(0, 7)),
           int'($urandom_range(0, 15)));
    end

    // Asynchronous reset while sample_tick is high every cycle.
    step(1'b1, 1'b1, 1'b1, 0, 0);
    run(5, 0);
    check_eq("pre_reset_sample", 32'(sample_tick), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("async_reset_sample", 32'(sample_tick), 32'd0);
    check_eq("async_reset_mid", 32'(mid_tick), 32'd0);
    check_eq("async_reset_bit", 32'(bit_tick), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    run(1400, 0);
    check_eq("post_reset_period", 32'(s_int), 32'd651);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
